serial_subtractor: RTL and testbench
====================================

# serial_subtractor

Digit-serial fixed-point subtractor: computes A − B two bits per cycle over N/2 cycles and reports the wrapped two's-complement difference with carry/borrow, overflow, true-sign and zero flags. It is the subtraction counterpart to the combinational 2-bit-slice adder chain in the fixed-point arithmetic library. It trades latency for area in the ODE datapath where difference terms are not timing-critical. Operands and results use valid/ready handshakes.

## Interface
- N, 16, operand/result width; must be even and ≥ 4
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operands A, B presented
- in_ready  output  1  block can accept operands
- A  input  N  minuend, two's complement
- B  input  N  subtrahend, two's complement
- out_valid  output  1  result and flags valid
- out_ready  input  1  consumer accepts result
- result  output  N  A − B (wrapped, or saturated per Configuration)
- carry  output  1  final carry-out of A + ~B + 1 (1 = no borrow)
- borrow  output  1  ~carry (unsigned A < B)
- overflow_flag  output  1  signed overflow
- negative  output  1  true sign of A − B (result[N−1] ^ overflow_flag)
- zero  output  1  result == 0

## Operation
- States: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid & in_ready: capture A and ~B into shift registers, carry register ← 1, digit counter ← 0, go to RUN.
- RUN: each cycle, slice j (bits 2j+1:2j) = A_digit + ~B_digit + carry. Shift the 2-bit sum into result register from the MSB end. Update carry. Record carry into the MSB (bit N−1) when j = N/2−1. Counter increments; after digit N/2−1, go to DONE.
- DONE: out_valid=1; result and flags held stable until out_valid & out_ready, then go to IDLE.
- overflow_flag = final carry ^ carry into bit N−1. zero evaluated on the presented result.
- in_ready=0 in RUN and DONE. in_valid is ignored there. A/B changes after capture have no effect.
- rst at any time: state ← IDLE; out_valid, result, carry, borrow, overflow_flag, negative, zero ← 0; in-flight operation discarded. in_ready=0 while rst high, 1 on the first cycle after.

## Timing
- Capture on edge E0. Digits computed on edges E1..E(N/2). out_valid high after E(N/2), i.e. N/2 cycles after acceptance (8 for N=16).
- out_ready already high when out_valid rises: handshake on the next edge, back to IDLE. Earliest next accept is one edge later. Minimum initiation interval is N/2+2 cycles.
- Outputs are registered; no combinational path from in_* to out_*. in_ready depends only on state and rst.
- out_ready low holds DONE indefinitely with outputs constant.

## Configuration
- SERIAL_SUB_SATURATE_EN defined: on overflow_flag=1, result is clamped to 1 followed by N−1 zeros if negative=1, else 0 followed by N−1 ones. carry, borrow, overflow_flag and negative are unchanged. zero reflects the clamped result.
- Not defined: result is the wrapped N-bit difference; no clamp logic is instantiated.

## Structure
- Shared fixed-point package: DIGIT_W = 2 constant, state enum (IDLE/RUN/DONE), saturation min/max constant functions of N.
- One sub-module: sub_slice2. Combinational 2-bit A + ~B + cin, outputting sum[1:0], cout and the carry into bit 1 (for overflow at the MSB slice).
- Top holds FSM, counter ($clog2(N/2) bits), operand/result shift registers, flag registers.

## Test plan
- N=16, A=0x0005, B=0x0003 -> after 8 cycles, result=0x0002, carry=1, borrow=0, overflow_flag=0, negative=0, zero=0.
- A=0x0003, B=0x0005 -> result=0xFFFE, borrow=1, negative=1, overflow_flag=0. A=B=0x1234 -> result=0, zero=1, carry=1.
- A=0x8000, B=0x0001 -> overflow_flag=1, negative=1. result=0x7FFF without the macro, 0x8000 with SERIAL_SUB_SATURATE_EN.
- A=0x7FFF, B=0xFFFF -> overflow_flag=1, negative=0. result=0x8000 without the macro, 0x7FFF with it.
- Backpressure: out_ready low 5 cycles after out_valid -> outputs stable, in_ready=0, in_valid ignored. out_ready high -> IDLE, next operand accepted one edge later.
- rst pulsed in third RUN cycle -> all outputs 0 next edge. A fresh operation afterwards produces the correct result with no residue.

Source files
------------

// File: rtl/serial_subtractor_pkg.sv
// Shared fixed-point definitions for the digit-serial subtractor:
// digit width, FSM state encoding and saturation bounds.
package serial_subtractor_pkg;

  localparam int DIGIT_W = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Largest positive two's-complement value of width n: 0 followed by ones.
  function automatic logic [63:0] sat_max(input int n);
    sat_max = (64'd1 << (n - 1)) - 64'd1;
  endfunction

  // Most negative two's-complement value of width n: 1 followed by zeros.
  function automatic logic [63:0] sat_min(input int n);
    sat_min = 64'd1 << (n - 1);
  endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Operand/result handshake bundle for serial_subtractor.
// The master drives operands and out_ready; the slave is the subtractor.
interface serial_subtractor_if #(
  parameter int N = 16
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] result;
  logic         carry;
  logic         borrow;
  logic         overflow_flag;
  logic         negative;
  logic         zero;

  modport master (
    output in_valid, A, B, out_ready,
    input  in_ready, out_valid, result, carry, borrow, overflow_flag, negative, zero
  );

  modport slave (
    input  in_valid, A, B, out_ready,
    output in_ready, out_valid, result, carry, borrow, overflow_flag, negative, zero
  );
endinterface

// File: rtl/serial_subtractor_sub_slice2.sv
// Combinational 2-bit slice computing a + nb + cin, where nb is the
// already-inverted subtrahend digit. c1 is the carry into the upper bit.
module sub_slice2
  import serial_subtractor_pkg::*;
(
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] nb,
  input  logic               cin,
  output logic [DIGIT_W-1:0] sum,
  output logic               cout,
  output logic               c1
);

  always_comb begin
    sum[0] = a[0] ^ nb[0] ^ cin;
    c1     = (a[0] & nb[0]) | (cin & (a[0] ^ nb[0]));
    sum[1] = a[1] ^ nb[1] ^ c1;
    cout   = (a[1] & nb[1]) | (c1 & (a[1] ^ nb[1]));
  end

endmodule

// File: rtl/serial_subtractor.sv
// Digit-serial A - B, two bits per cycle, with carry/borrow/overflow/sign/zero.
// Optional SERIAL_SUB_SATURATE_EN clamps the result on signed overflow.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int N = 16  // even, >= 4
) (
  input  logic                clk,
  input  logic                rst,
  serial_subtractor_if.slave  bus
);

  localparam int DIGITS = N / DIGIT_W;
  localparam int CNT_W  = $clog2(DIGITS);
  localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(DIGITS - 1);

  state_t state_reg, state_next;

  logic [CNT_W-1:0]   cnt_reg;
  logic [N-1:0]       a_sh_reg;
  logic [N-1:0]       nb_sh_reg;
  logic [N-3:0]       res_sh_reg;
  logic               cin_reg;

  logic [N-1:0]       result_reg;
  logic               carry_reg;
  logic               borrow_reg;
  logic               ovf_reg;
  logic               neg_reg;
  logic               zero_reg;

  logic [DIGIT_W-1:0] digit_sum;
  logic               digit_cout;
  logic               digit_c1;
  logic [N-1:0]       res_full;
  logic               last_digit;

  logic [N-1:0]       result_next;
  logic               ovf_next;
  logic               neg_next;

  sub_slice2 u_slice (
    .a    (a_sh_reg[DIGIT_W-1:0]),
    .nb   (nb_sh_reg[DIGIT_W-1:0]),
    .cin  (cin_reg),
    .sum  (digit_sum),
    .cout (digit_cout),
    .c1   (digit_c1)
  );

  // New digit enters at the MSB end; after the last digit this is the full difference.
  assign res_full   = {digit_sum, res_sh_reg};
  assign last_digit = (state_reg == RUN) && (cnt_reg == LAST_DIGIT);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.in_valid) state_next = RUN;
      RUN:     if (cnt_reg == LAST_DIGIT) state_next = DONE;
      DONE:    if (bus.out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    bus.in_ready  = (state_reg == IDLE) && !rst;
    bus.out_valid = (state_reg == DONE);
  end

  // Flags at the MSB slice: carry into bit N-1 is the slice's internal c1.
  always_comb begin
    ovf_next = digit_cout ^ digit_c1;
    neg_next = res_full[N-1] ^ ovf_next;
`ifdef SERIAL_SUB_SATURATE_EN
    if (ovf_next) result_next = neg_next ? sat_min(N)  >> 0 : sat_max(N) >> 0;
    else          result_next = res_full;
`else
    result_next = res_full;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg    <= '0;
      a_sh_reg   <= '0;
      nb_sh_reg  <= '0;
      res_sh_reg <= '0;
      cin_reg    <= 1'b0;
      result_reg <= '0;
      carry_reg  <= 1'b0;
      borrow_reg <= 1'b0;
      ovf_reg    <= 1'b0;
      neg_reg    <= 1'b0;
      zero_reg   <= 1'b0;
    end else if (state_reg == IDLE) begin
      if (bus.in_valid) begin
        a_sh_reg  <= bus.A;
        nb_sh_reg <= ~bus.B;
        cin_reg   <= 1'b1;
        cnt_reg   <= '0;
      end
    end else if (state_reg == RUN) begin
      a_sh_reg   <= a_sh_reg >> DIGIT_W;
      nb_sh_reg  <= nb_sh_reg >> DIGIT_W;
      res_sh_reg <= res_full[N-1:DIGIT_W];
      cin_reg    <= digit_cout;
      cnt_reg    <= cnt_reg + 1'b1;
      if (last_digit) begin
        result_reg <= result_next;
        carry_reg  <= digit_cout;
        borrow_reg <= ~digit_cout;
        ovf_reg    <= ovf_next;
        neg_reg    <= neg_next;
        zero_reg   <= (result_next == '0);
      end
    end
  end

  assign bus.result        = result_reg;
  assign bus.carry         = carry_reg;
  assign bus.borrow        = borrow_reg;
  assign bus.overflow_flag = ovf_reg;
  assign bus.negative      = neg_reg;
  assign bus.zero          = zero_reg;

endmodule

// File: tb/tb_serial_subtractor.sv
// Randomised self-checking bench for serial_subtractor (N=16); honours
// SERIAL_SUB_SATURATE_EN in its reference model when defined.
module tb_serial_subtractor;

  localparam int N      = 16;
  localparam int DIGITS = N / 2;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  serial_subtractor_if #(.N(N)) bus ();

  serial_subtractor #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operand values.
  task automatic model(input logic [15:0] a, input logic [15:0] b,
                       output logic [15:0] r, output logic [4:0] flags);
    int  sd;
    logic c, ov, ng;
    sd = int'($signed(a)) - int'($signed(b));
    c  = (a >= b);
    ov = (sd > 32767) || (sd < -32768);
    ng = (sd < 0);
    r  = 16'(sd);
`ifdef SERIAL_SUB_SATURATE_EN
    if (ov) r = ng ? 16'h8000 : 16'h7FFF;
`endif
    flags = {c, !c, ov, ng, (r == 16'h0000)};
  endtask

  function automatic logic [4:0] dut_flags();
    return {bus.carry, bus.borrow, bus.overflow_flag, bus.negative, bus.zero};
  endfunction

  // Presents one operand pair, checks latency and results, then drains with
  // out_ready held low for 'hold' cycles. Called at posedge+#1.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input int hold);
    logic [15:0] r;
    logic [4:0]  fl;
    int          waitc;
    int          lat;
    waitc = 0;
    while (!bus.in_ready && waitc < 50) begin
      @(posedge clk); #1;
      waitc++;
    end
    if (!bus.in_ready) begin
      check_eq("accept_timeout", 32'd0, 32'd1);
      return;
    end
    model(a, b, r, fl);
    bus.in_valid  = 1'b1;
    bus.A         = a;
    bus.B         = b;
    bus.out_ready = (hold == 0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.A        = 16'($urandom);
    bus.B        = 16'($urandom);
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check_eq("latency", lat, DIGITS);
    check_eq("result", bus.result, r);
    check_eq("flags", dut_flags(), fl);
    $display("TXN A=%04h B=%04h result=%04h c=%0b b=%0b ov=%0b n=%0b z=%0b hold=%0d",
             a, b, bus.result, bus.carry, bus.borrow, bus.overflow_flag,
             bus.negative, bus.zero, hold);
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = 1'b1;
      bus.A        = 16'($urandom);
      bus.B        = 16'($urandom);
      @(posedge clk); #1;
      check_eq("hold_valid", bus.out_valid, 1'b1);
      check_eq("hold_in_ready", bus.in_ready, 1'b0);
      check_eq("hold_result", bus.result, r);
      check_eq("hold_flags", dut_flags(), fl);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check_eq("drain_valid", bus.out_valid, 1'b0);
    check_eq("drain_in_ready", bus.in_ready, 1'b1);
  endtask

  // Aborts an operation with rst in its third RUN cycle.
  task automatic reset_mid_run(input logic [15:0] a, input logic [15:0] b);
    bus.in_valid  = 1'b1;
    bus.A         = a;
    bus.B         = b;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check_eq("rst_in_ready", bus.in_ready, 1'b0);
    @(posedge clk); #1;
    check_eq("rst_valid", bus.out_valid, 1'b0);
    check_eq("rst_result", bus.result, 16'h0000);
    check_eq("rst_flags", dut_flags(), 5'b0);
    rst = 1'b0;
    #1;
    check_eq("post_rst_in_ready", bus.in_ready, 1'b1);
    $display("TXN reset during RUN A=%04h B=%04h", a, b);
  endtask

  initial begin
    logic [15:0] ra, rb;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.A         = '0;
    bus.B         = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_in_ready", bus.in_ready, 1'b0);
    check_eq("reset_valid", bus.out_valid, 1'b0);
    check_eq("reset_result", bus.result, 16'h0000);
    check_eq("reset_flags", dut_flags(), 5'b0);
    rst = 1'b0;
    #1;
    check_eq("idle_in_ready", bus.in_ready, 1'b1);

    run_op(16'h0005, 16'h0003, 0);
    reset_mid_run(16'h4321, 16'h1111);
    run_op(16'h0003, 16'h0005, 0);
    run_op(16'h1234, 16'h1234, 0);
    run_op(16'h8000, 16'h0001, 0);
    run_op(16'h7FFF, 16'hFFFF, 0);
    run_op(16'hA5A5, 16'h5A5A, 5);
    run_op(16'h0000, 16'h0000, 1);
    run_op(16'h8000, 16'h8000, 0);
    run_op(16'h0000, 16'h8000, 2);

    for (int k = 0; k < 40; k++) begin
      ra = 16'($urandom);
      rb = (k % 8 == 0) ? ra : 16'($urandom);
      run_op(ra, rb, int'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
